// File: rtl/led_mode_ctrl.sv
// Key-driven LED mode controller: KEY synchroniser, press detection and an OFF/ON/SLOW/FAST blink sequencer.
// Build option: define LED_KEY_DEBOUNCE_EN to insert the debounce filter between the synchroniser and press detection.
module led_mode_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int SLOW_HALF  = 8,
    parameter int FAST_HALF  = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY,
    output logic       LED,
    output logic [1:0] STATE,
    output logic       KEY_PULSE
);
    localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(HALF_MAX + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] SLOW_LAST  = HW'(SLOW_HALF - 1);
    localparam logic [HW-1:0] FAST_LAST  = HW'(FAST_HALF - 1);

    if (TICK_DIV < 1 || SLOW_HALF < 1 || FAST_HALF < 1 || DEB_CYCLES < 1) begin : g_param_check
        $error("led_mode_ctrl: all timing parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_SLOW = 2'd2,
        S_FAST = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      sync_reg;
    logic            level;
    logic            level_d_reg;
    logic            press;
    logic [PW-1:0]   presc_reg;
    logic [HW-1:0]   half_reg;
    logic [HW-1:0]   half_last;
    logic            phase_reg;
    logic            led_reg, led_next;
    logic            key_pulse_reg;

    // sync_reg[0] is the first stage, sync_reg[1] the second
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], KEY};
        end
    end

`ifdef LED_KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt_reg;
    logic          level_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            deb_cnt_reg <= '0;
            level_reg   <= 1'b0;
        end else if (sync_reg[1] == level_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            level_reg   <= sync_reg[1];
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
        end
    end

    assign level = level_reg;
`else
    assign level = sync_reg[1];
`endif

    // Only the rising edge of the filtered level counts; release is ignored
    assign press = level & ~level_d_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            level_d_reg   <= 1'b0;
            key_pulse_reg <= 1'b0;
            state_reg     <= S_OFF;
            led_reg       <= 1'b0;
        end else begin
            level_d_reg   <= level;
            key_pulse_reg <= press;
            state_reg     <= state_next;
            led_reg       <= led_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        led_next   = 1'b0;
        half_last  = SLOW_LAST;
        case (state_reg)
            S_OFF: begin
                if (press) state_next = S_ON;
            end
            S_ON: begin
                led_next = 1'b1;
                if (press) state_next = S_SLOW;
            end
            S_SLOW: begin
                led_next = phase_reg;
                if (press) state_next = S_FAST;
            end
            S_FAST: begin
                led_next  = phase_reg;
                half_last = FAST_LAST;
                if (press) state_next = S_OFF;
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    // Every press changes mode, so a press always restarts the blink pattern at phase 1
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_reg <= '0;
            half_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (press) begin
            presc_reg <= '0;
            half_reg  <= '0;
            phase_reg <= 1'b1;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
            if (half_reg == half_last) begin
                half_reg  <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                half_reg <= half_reg + HW'(1);
            end
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    assign LED       = led_reg;
    assign STATE     = state_reg;
    assign KEY_PULSE = key_pulse_reg;

endmodule
